mmc1_ctrl: RTL and testbench

MMC1_CTRL -- requirements
Module: mmc1_ctrl

---
 rtl/mmc1_pkg.sv | 28 ++
 rtl/mmc1_if.sv | 10 +
 rtl/mmc1_shift.sv | 41 ++++
 rtl/mmc1_ctrl.sv | 88 ++++++++
 tb/tb_mmc1_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mmc1_pkg.sv
// rtl/mmc1_pkg.sv - shared encodings for the MMC1 mapper controller
package mmc1_pkg;

    typedef enum logic [1:0] {
        SEL_CTRL = 2'd0,
        SEL_CHR0 = 2'd1,
        SEL_CHR1 = 2'd2,
        SEL_PRG  = 2'd3
    } reg_sel_t;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORZ   = 2'd3
    } mirror_t;

    typedef enum logic [1:0] {
        PRG_32K_A     = 2'd0,
        PRG_32K_B     = 2'd1,
        PRG_FIX_FIRST = 2'd2,
        PRG_FIX_LAST  = 2'd3
    } prg_mode_t;

    // Fixed-last-bank PRG mode, one-screen-low mirroring, 8KB CHR
    localparam logic [4:0] CTRL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_if.sv
// rtl/mmc1_if.sv - CPU bus view of the $8000-$FFFF mapper window
interface mmc1_if;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic        cpu_rw;
    logic        romsel;

    modport master (output cpu_addr, cpu_data_i, cpu_rw, romsel);
    modport slave  (input  cpu_addr, cpu_data_i, cpu_rw, romsel);
endinterface

// File: rtl/mmc1_shift.sv
// rtl/mmc1_shift.sv - MMC1 serial loader: 5-bit LSB-first shift with back-to-back write filter
module mmc1_shift (
    input  logic       clk_cpu,
    input  logic       rst_n,
    input  logic       wr_cycle,
    input  logic       data_bit,
    input  logic       reset_bit,
    output logic       load_stb,
    output logic [4:0] load_value,
    output logic       reset_stb
);

    logic [4:0] shift_q;
    logic [2:0] count_q;
    logic       last_accept_q;
    logic       accept;

    // A write right after an accepted one is the dummy cycle of a CPU read-modify-write
    assign accept     = wr_cycle & ~last_accept_q;
    assign reset_stb  = accept & reset_bit;
    assign load_stb   = accept & ~reset_bit & (count_q == 3'd4);
    assign load_value = {data_bit, shift_q[4:1]};

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            shift_q       <= '0;
            count_q       <= '0;
            last_accept_q <= 1'b0;
        end else begin
            last_accept_q <= accept;
            if (reset_stb || load_stb) begin
                shift_q <= '0;
                count_q <= '0;
            end else if (accept) begin
                shift_q <= {data_bit, shift_q[4:1]};
                count_q <= count_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mmc1_ctrl.sv
// rtl/mmc1_ctrl.sv - MMC1 register file and PRG/CHR bank mapping
module mmc1_ctrl
    import mmc1_pkg::*;
#(
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5
) (
    input  logic                     clk_cpu,
    input  logic                     rst_n,
    mmc1_if.slave                    bus,
    output logic [PRG_BANK_BITS-1:0] prg_bank,
    output logic [CHR_BANK_BITS-1:0] chr_bank0,
    output logic [CHR_BANK_BITS-1:0] chr_bank1,
    output logic                     chr_mode,
    output logic [1:0]               mirror,
    output logic                     prg_ram_en,
    output logic                     cfg_commit
);

    logic [4:0]               ctrl_q;
    logic [CHR_BANK_BITS-1:0] chr0_q;
    logic [CHR_BANK_BITS-1:0] chr1_q;
    logic [PRG_BANK_BITS-1:0] prg_q;
    logic                     prg_ram_dis_q;

    logic       load_stb;
    logic       reset_stb;
    logic [4:0] load_value;
    logic       unused_bus;

    assign unused_bus = &{1'b0, bus.cpu_addr[12:0], bus.cpu_data_i[6:1]};

    mmc1_shift u_shift (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .wr_cycle   (bus.romsel & ~bus.cpu_rw),
        .data_bit   (bus.cpu_data_i[0]),
        .reset_bit  (bus.cpu_data_i[7]),
        .load_stb   (load_stb),
        .load_value (load_value),
        .reset_stb  (reset_stb)
    );

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            ctrl_q        <= CTRL_RESET;
            chr0_q        <= '0;
            chr1_q        <= '0;
            prg_q         <= '0;
            prg_ram_dis_q <= 1'b0;
            cfg_commit    <= 1'b0;
        end else begin
            cfg_commit <= load_stb | reset_stb;
            if (reset_stb) begin
                ctrl_q <= ctrl_q | CTRL_RESET;
            end else if (load_stb) begin
                case (reg_sel_t'(bus.cpu_addr[14:13]))
                    SEL_CTRL: ctrl_q <= load_value;
                    SEL_CHR0: chr0_q <= CHR_BANK_BITS'(load_value);
                    SEL_CHR1: chr1_q <= CHR_BANK_BITS'(load_value);
                    SEL_PRG: begin
                        prg_q         <= PRG_BANK_BITS'(load_value);
                        prg_ram_dis_q <= load_value[4];
                    end
                    default: ;
                endcase
            end
        end
    end

    // cpu_addr[14] selects the $8000 or $C000 half of the PRG window
    always_comb begin
        prg_bank = prg_q;
        case (prg_mode_t'(ctrl_q[3:2]))
            PRG_32K_A, PRG_32K_B: prg_bank = {prg_q[PRG_BANK_BITS-1:1], bus.cpu_addr[14]};
            PRG_FIX_FIRST:        prg_bank = bus.cpu_addr[14] ? prg_q : '0;
            PRG_FIX_LAST:         prg_bank = bus.cpu_addr[14] ? '1 : prg_q;
            default: ;
        endcase
    end

    assign chr_bank0  = chr0_q;
    assign chr_bank1  = chr1_q;
    assign mirror     = ctrl_q[1:0];
    assign chr_mode   = ctrl_q[4];
    assign prg_ram_en = ~prg_ram_dis_q;

endmodule

// File: tb/tb_mmc1_ctrl.sv
// tb/tb_mmc1_ctrl.sv - directed vector bench for mmc1_ctrl
module tb_mmc1_ctrl;

    logic       clk_cpu = 1'b0;
    logic       rst_n;
    logic [3:0] prg_bank;
    logic [4:0] chr_bank0;
    logic [4:0] chr_bank1;
    logic       chr_mode;
    logic [1:0] mirror;
    logic       prg_ram_en;
    logic       cfg_commit;

    int total = 0;
    int bad   = 0;

    always #5 clk_cpu = ~clk_cpu;

    mmc1_if bus ();

    mmc1_ctrl #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5)) dut (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .bus        (bus),
        .prg_bank   (prg_bank),
        .chr_bank0  (chr_bank0),
        .chr_bank1  (chr_bank1),
        .chr_mode   (chr_mode),
        .mirror     (mirror),
        .prg_ram_en (prg_ram_en),
        .cfg_commit (cfg_commit)
    );

    typedef struct {
        logic        rn;
        logic        ro;
        logic        rw;
        logic [14:0] a;
        logic [7:0]  d;
        logic        cc;
        logic        chk;
        logic [3:0]  pb;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic        cm;
        logic [1:0]  mir;
        logic        ram;
    } vec_t;

    vec_t vq[$];

    task automatic push(input logic rn, input logic ro, input logic rw, input logic [14:0] a,
                        input logic [7:0] d, input logic cc, input logic chk, input logic [3:0] pb,
                        input logic [4:0] c0, input logic [4:0] c1, input logic cm,
                        input logic [1:0] mir, input logic ram);
        vec_t v;
        v.rn = rn; v.ro = ro; v.rw = rw; v.a = a; v.d = d; v.cc = cc; v.chk = chk;
        v.pb = pb; v.c0 = c0; v.c1 = c1; v.cm = cm; v.mir = mir; v.ram = ram;
        vq.push_back(v);
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic cc);
        push(1, 1, 0, a, d, cc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd();
        push(1, 1, 1, 15'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sw(input logic [14:0] a, input logic [7:0] d, input logic cc);
        wr(a, d, cc);
        rd();
    endtask

    task automatic ck(input logic [14:0] a, input logic [3:0] pb, input logic [4:0] c0,
                      input logic [4:0] c1, input logic cm, input logic [1:0] mir, input logic ram);
        push(1, 1, 1, a, 8'h00, 0, 1, pb, c0, c1, cm, mir, ram);
    endtask

    task automatic rs();
        push(0, 0, 1, 15'h0000, 8'h00, 0, 1, 4'h0, 5'h00, 5'h00, 0, 2'd0, 1);
    endtask

    task automatic cmp(input string nm, input int step, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, step, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.romsel = 1'b0;
        bus.cpu_rw = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_data_i = '0;

        // reset state, both PRG halves
        rs();
        ck(15'h4000, 4'hF, 5'h00, 5'h00, 0, 2'd0, 1);

        // prg <= 0x05 via spaced writes to $E000
        sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h00, 0); sw(15'h6000, 8'h01, 0);
        sw(15'h6000, 8'h00, 0); sw(15'h6000, 8'h00, 1);
        ck(15'h0000, 4'h5, 5'h00, 5'h00, 0, 2'd0, 1);
        ck(15'h4000, 4'hF, 5'h00, 5'h00, 0, 2'd0, 1);

        // back-to-back pair: second write dropped, commit on sixth write
        wr(15'h2000, 8'h01, 0); wr(15'h2000, 8'h00, 0); rd();
        sw(15'h2000, 8'h01, 0); sw(15'h2000, 8'h01, 0); sw(15'h2000, 8'h00, 0);
        wr(15'h2000, 8'h01, 1);
        ck(15'h0000, 4'h5, 5'h17, 5'h00, 0, 2'd0, 1);

        // three shifts then reset write; next five load chr1 = 0x06
        sw(15'h4000, 8'h01, 0); sw(15'h4000, 8'h01, 0); sw(15'h4000, 8'h01, 0);
        sw(15'h4000, 8'h80, 1);
        ck(15'h0000, 4'h5, 5'h17, 5'h00, 0, 2'd0, 1);
        sw(15'h4000, 8'h00, 0); sw(15'h4000, 8'h01, 0); sw(15'h4000, 8'h01, 0);
        sw(15'h4000, 8'h00, 0); sw(15'h4000, 8'h00, 1);
        ck(15'h0000, 4'h5, 5'h17, 5'h06, 0, 2'd0, 1);

        // control=0x02 (32K mode, vertical), prg=0x06
        sw(15'h0000, 8'h00, 0); sw(15'h0000, 8'h01, 0); sw(15'h0000, 8'h00, 0);
        sw(15'h0000, 8'h00, 0); sw(15'h0000, 8'h00, 1);
        sw(15'h6000, 8'h00, 0); sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h01, 0);
        sw(15'h6000, 8'h00, 0); sw(15'h6000, 8'h00, 1);
        ck(15'h0000, 4'h6, 5'h17, 5'h06, 0, 2'd2, 1);
        ck(15'h4000, 4'h7, 5'h17, 5'h06, 0, 2'd2, 1);

        // reset write ORs 0x0C into control: 0x02 -> 0x0E
        sw(15'h0000, 8'h80, 1);
        ck(15'h0000, 4'h6, 5'h17, 5'h06, 0, 2'd2, 1);
        ck(15'h4000, 4'hF, 5'h17, 5'h06, 0, 2'd2, 1);

        // bit7 together with count=4: reset only, prg untouched
        sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h01, 0);
        sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h81, 1);
        ck(15'h0000, 4'h6, 5'h17, 5'h06, 0, 2'd2, 1);

        // control=0x08 (fix first), prg=0x13 -> bank 3, PRG RAM off
        sw(15'h0000, 8'h00, 0); sw(15'h0000, 8'h00, 0); sw(15'h0000, 8'h00, 0);
        sw(15'h0000, 8'h01, 0); sw(15'h0000, 8'h00, 1);
        sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h01, 0); sw(15'h6000, 8'h00, 0);
        sw(15'h6000, 8'h00, 0); sw(15'h6000, 8'h01, 1);
        ck(15'h0000, 4'h0, 5'h17, 5'h06, 0, 2'd0, 0);
        ck(15'h4000, 4'h3, 5'h17, 5'h06, 0, 2'd0, 0);

        // control=0x1F: horizontal, fix last, 4KB CHR
        sw(15'h0000, 8'h01, 0); sw(15'h0000, 8'h01, 0); sw(15'h0000, 8'h01, 0);
        sw(15'h0000, 8'h01, 0); sw(15'h0000, 8'h01, 1);
        ck(15'h0000, 4'h3, 5'h17, 5'h06, 1, 2'd3, 0);
        ck(15'h4000, 4'hF, 5'h17, 5'h06, 1, 2'd3, 0);

        // reset mid-sequence, romsel=0 write ignored, chr1 = 0x09
        sw(15'h2000, 8'h01, 0); sw(15'h2000, 8'h01, 0);
        rs();
        ck(15'h4000, 4'hF, 5'h00, 5'h00, 0, 2'd0, 1);
        wr(15'h4000, 8'h01, 0);
        push(1, 0, 0, 15'h4000, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0);
        wr(15'h4000, 8'h00, 0); rd();
        sw(15'h4000, 8'h00, 0); sw(15'h4000, 8'h01, 0);
        wr(15'h4000, 8'h00, 1);
        ck(15'h0000, 4'h0, 5'h00, 5'h09, 0, 2'd0, 1);

        // write right after a reset write is dropped; chr0 = 0x0F
        wr(15'h2000, 8'h80, 1); wr(15'h2000, 8'h01, 0); rd();
        sw(15'h2000, 8'h01, 0); sw(15'h2000, 8'h01, 0); sw(15'h2000, 8'h01, 0);
        sw(15'h2000, 8'h01, 0); wr(15'h2000, 8'h00, 1);
        ck(15'h0000, 4'h0, 5'h0F, 5'h09, 0, 2'd0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n          = vq[i].rn;
            bus.romsel     = vq[i].ro;
            bus.cpu_rw     = vq[i].rw;
            bus.cpu_addr   = vq[i].a;
            bus.cpu_data_i = vq[i].d;
            @(posedge clk_cpu);
            #1;
            cmp("cfg_commit", i, {7'd0, cfg_commit}, {7'd0, vq[i].cc});
            if (vq[i].chk) begin
                cmp("prg_bank",   i, {4'd0, prg_bank},   {4'd0, vq[i].pb});
                cmp("chr_bank0",  i, {3'd0, chr_bank0},  {3'd0, vq[i].c0});
                cmp("chr_bank1",  i, {3'd0, chr_bank1},  {3'd0, vq[i].c1});
                cmp("chr_mode",   i, {7'd0, chr_mode},   {7'd0, vq[i].cm});
                cmp("mirror",     i, {6'd0, mirror},     {6'd0, vq[i].mir});
                cmp("prg_ram_en", i, {7'd0, prg_ram_en}, {7'd0, vq[i].ram});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
